bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential converter from a packed multi-digit BCD value to plain binary. It is the read side of the decimal counter chain: it consumes the digit vector assembled from cascaded decimal counters and produces a binary value for arithmetic or compare logic. It processes one digit per clock, most significant digit first, using multiply-by-10-and-add. Input and output each use a valid/ready handshake.

Parameters:
p_digits, 4, number of BCD digits in i_val (>=1)
p_width, 14, output width in bits; must be >= ceil(log2(10^p_digits)) (4 digits -> 14)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-low (0 = reset)
i_val  input  4*p_digits  packed BCD; digit k occupies [4k+3:4k], digit p_digits-1 is MSD
i_vld  input  1  i_val valid
o_rdy  output 1  converter can accept i_val
o_val  output p_width  binary result
o_vld  output 1  o_val/o_err valid
i_rdy  input  1  downstream accepts o_val
o_err  output 1  at least one input digit was > 9

Behaviour:
- States: IDLE, CONV, DONE. Register set: state, digit shift register (4*p_digits), accumulator (p_width), digit counter (ceil(log2(p_digits+1)) bits), error flag.
- Reset (i_rst=0 at an edge): state=IDLE, accumulator=0, o_val=0, o_vld=0, o_err=0, counter=0. Reset overrides every other input. A reset during CONV or DONE aborts the conversion and drops the result without presenting it.
- o_rdy = (state==IDLE) and i_rst==1; combinational from state. o_vld = (state==DONE); registered through state.
- IDLE: input handshake when i_vld & o_rdy at an edge. Latch i_val into the shift register, clear accumulator, counter and error, then go to CONV. Without a handshake, stay in IDLE and hold o_val.
- CONV, each edge:
  - d = top 4 bits of the shift register.
  - acc <= acc*10 + d, computed at p_width+4 bits and truncated to p_width (modulo 2^p_width).
  - Shift register shifts left by 4.
  - err <= err | (d > 9).
  - counter++.
  - On the edge that processes digit p_digits (the LSD), go to DONE.
- Invalid digits (A-F) are still accumulated at their face value (10..15) and set o_err. No saturation.
- DONE: o_val = accumulator and o_err = error flag, both held stable while o_vld=1. When i_rdy=1 at an edge, go to IDLE. o_val and o_err keep their last value in IDLE.
- Latency: input handshake at edge T gives o_vld=1 after edge T+p_digits. Minimum period between accepts is p_digits+2 cycles (DONE with i_rdy=1 costs one cycle, IDLE with i_vld=1 costs one cycle).
- i_vld during CONV/DONE is ignored (o_rdy=0). The upstream block must hold i_val until it sees the handshake.
- i_rdy is ignored outside DONE. A long i_rdy=0 stalls the converter in DONE indefinitely with no data loss.
- p_digits=1: CONV lasts a single cycle; o_val = digit value.

Test Plan:
- Reset, then i_val=16'h1234 with i_vld=1 and i_rdy=1 -> o_rdy drops after accept; o_vld=1 exactly 4 cycles after the accept edge; o_val=1234 (14'h04D2), o_err=0; back in IDLE one cycle later.
- i_val=16'h9999 and 16'h0000 back-to-back, i_vld held -> o_val=9999 (14'h270F) then 0. Accepts are 6 cycles apart. o_err=0 on both.
- i_val=16'h12A4 -> o_val=1304, o_err=1. Then 16'h0001 -> o_val=1, o_err=0 (error flag clears on the new accept).
- Backpressure: i_val=16'h0042 with i_rdy=0 for 10 cycles after o_vld rises -> o_vld and o_val=42 held stable throughout, o_rdy=0, and a new i_vld is not accepted. When i_rdy=1, IDLE is reached on the next edge.
- Reset mid-operation: i_rst=0 on the 2nd CONV cycle of 16'h5678 -> next cycle state IDLE, o_vld=0, o_val=0, o_err=0, o_rdy=1. No stale result appears afterwards.
- p_digits=1, p_width=4: i_val=4'h7 -> o_val=7 after 1 cycle. i_val=4'hF -> o_val=15, o_err=1.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Valid/ready handshake on both the BCD input and the binary result.
module bcd_to_bin #(
  parameter int p_digits = 4,
  parameter int p_width  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*p_digits-1:0] i_val,
  input  logic                  i_vld,
  output logic                  o_rdy,
  output logic [p_width-1:0]    o_val,
  output logic                  o_vld,
  input  logic                  i_rdy,
  output logic                  o_err
);
  localparam int CW = $clog2(p_digits + 1);
  localparam int SW = 4 * p_digits;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state, state_nxt;
  logic [SW-1:0]      sr;
  logic [p_width-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               err;
  logic [3:0]         d;
  logic [p_width+3:0] prod;
  logic               last;
  logic               err_nxt;

  assign d       = sr[SW-1 -: 4];
  // Wide multiply-add; truncation to p_width gives the modulo behaviour.
  assign prod    = ({4'b0, acc} * (p_width+4)'(10)) + {{p_width{1'b0}}, d};
  assign err_nxt = err | (d > 4'd9);
  assign last    = (cnt == CW'(p_digits - 1));
  assign o_rdy   = (state == IDLE) && i_rst;
  assign o_vld   = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_vld) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    if (i_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sr    <= '0;
      acc   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      o_val <= '0;
      o_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_vld) begin
          sr  <= i_val;
          acc <= '0;
          cnt <= '0;
          err <= 1'b0;
        end
        CONV: begin
          acc <= prod[p_width-1:0];
          sr  <= sr << 4;
          err <= err_nxt;
          cnt <= cnt + CW'(1);
          // Result registers only change when a conversion completes.
          if (last) begin
            o_val <= prod[p_width-1:0];
            o_err <= err_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: 4-digit instance plus a 1-digit instance.
module tb_bcd_to_bin;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val;
  logic        vld, rdy;
  logic        o_rdy, o_vld, o_err;
  logic [13:0] o_val;

  logic [3:0]  val1;
  logic        vld1, rdy1;
  logic        o_rdy1, o_vld1, o_err1;
  logic [3:0]  o_val1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int acc_cyc;
  int prev_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_to_bin #(.p_digits(4), .p_width(14)) dut (
    .i_clk(clk), .i_rst(rst), .i_val(val), .i_vld(vld), .o_rdy(o_rdy),
    .o_val(o_val), .o_vld(o_vld), .i_rdy(rdy), .o_err(o_err)
  );

  bcd_to_bin #(.p_digits(1), .p_width(4)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_val(val1), .i_vld(vld1), .o_rdy(o_rdy1),
    .o_val(o_val1), .o_vld(o_vld1), .i_rdy(rdy1), .o_err(o_err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present v, wait for the accept edge, then for the result; leaves DUT in IDLE.
  task automatic conv(input logic [15:0] v, input logic [13:0] ev, input logic ee,
                      input string tag);
    int n;
    val = v; vld = 1'b1; rdy = 1'b1;
    n = 0;
    while (!o_rdy && n < 20) begin tick(); n++; end
    chk({tag, "_rdy_to"}, 32'(n < 20), 32'd1);
    tick();
    acc_cyc = cyc;
    chk({tag, "_rdy_drop"}, 32'(o_rdy), 32'd0);
    n = 0;
    while (!o_vld && n < 20) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(cyc - acc_cyc), 32'd4);
    chk({tag, "_val"}, 32'(o_val), 32'(ev));
    chk({tag, "_err"}, 32'(o_err), 32'(ee));
    tick();
    chk({tag, "_idle"}, 32'(o_rdy), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b0; val = '0; vld = 1'b0; rdy = 1'b0;
    val1 = '0; vld1 = 1'b0; rdy1 = 1'b0;
    tick(); tick();
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_val", 32'(o_val), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_rdy_low", 32'(o_rdy), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_rdy", 32'(o_rdy), 32'd1);

    conv(16'h1234, 14'd1234, 1'b0, "c1234");

    // Back-to-back with i_vld held high throughout.
    conv(16'h9999, 14'd9999, 1'b0, "c9999");
    prev_acc = acc_cyc;
    conv(16'h0000, 14'd0, 1'b0, "c0000");
    chk("b2b_period", 32'(acc_cyc - prev_acc), 32'd6);

    conv(16'h12A4, 14'd1304, 1'b1, "c12a4");
    conv(16'h0001, 14'd1, 1'b0, "c0001");
    vld = 1'b0;

    // Backpressure: result must hold while a competing request waits.
    val = 16'h0042; vld = 1'b1; rdy = 1'b0;
    tick();
    val = 16'h9999;
    n = 0;
    while (!o_vld && n < 20) begin tick(); n++; end
    chk("bp_lat", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_vld", 32'(o_vld), 32'd1);
      chk("bp_val", 32'(o_val), 32'd42);
      chk("bp_rdy", 32'(o_rdy), 32'd0);
    end
    rdy = 1'b1;
    tick();
    vld = 1'b0;
    chk("bp_rel_vld", 32'(o_vld), 32'd0);
    chk("bp_rel_rdy", 32'(o_rdy), 32'd1);
    chk("bp_rel_val", 32'(o_val), 32'd42);

    // Reset on the second CONV cycle drops the conversion.
    val = 16'h5678; vld = 1'b1; rdy = 1'b1;
    tick();
    vld = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mrst_vld", 32'(o_vld), 32'd0);
    chk("mrst_val", 32'(o_val), 32'd0);
    chk("mrst_err", 32'(o_err), 32'd0);
    chk("mrst_rdy", 32'(o_rdy), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (o_vld) n++;
    end
    chk("mrst_stale", 32'(n), 32'd0);

    // Single-digit instance.
    val1 = 4'h7; vld1 = 1'b1; rdy1 = 1'b1;
    tick();
    vld1 = 1'b0;
    chk("d1_conv", 32'(o_vld1), 32'd0);
    tick();
    chk("d1_vld7", 32'(o_vld1), 32'd1);
    chk("d1_val7", 32'(o_val1), 32'd7);
    chk("d1_err7", 32'(o_err1), 32'd0);
    tick();
    val1 = 4'hF; vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    tick();
    chk("d1_vldF", 32'(o_vld1), 32'd1);
    chk("d1_valF", 32'(o_val1), 32'd15);
    chk("d1_errF", 32'(o_err1), 32'd1);
    tick();
    chk("d1_idle", 32'(o_rdy1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
